// File: rtl/ntt_bfly_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_bfly_scheduler
//  Description : Address/twiddle sequencer for an iterative radix-2
//                Cooley-Tukey NTT. Walks all LOGN stages and issues one
//                butterfly descriptor (addr_a, addr_b, tw_idx, stage) per
//                accepted valid/ready transfer.
//  Options     : NTT_SCHED_STAGE_GAP_EN -- inserts GAP idle cycles
//                (valid=0, busy=1) between stages so the butterfly pipeline
//                can drain before the next stage reads its results.
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_bfly_scheduler #(
  parameter int LOGN = 3,
  parameter int GAP  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      ready,
  output logic                      valid,
  output logic [LOGN-1:0]           addr_a,
  output logic [LOGN-1:0]           addr_b,
  output logic [LOGN-2:0]           tw_idx,
  output logic [$clog2(LOGN)-1:0]   stage,
  output logic                      busy,
  output logic                      done
);

  localparam int SW = $clog2(LOGN);
  localparam logic [SW-1:0]   S_LAST = SW'(LOGN - 1);
  localparam logic [LOGN-2:0] K_LAST = '1;

  // Elaboration-time guard against illegal parameter combinations
  if (LOGN < 2 || LOGN > 12 || GAP < 0 || GAP > 15) begin : g_param_check
    $error("ntt_bfly_scheduler: LOGN must be 2..12 and GAP 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [LOGN-2:0]   k_q, k_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [LOGN-1:0]   addr_a_q, addr_a_d;
  logic [LOGN-1:0]   addr_b_q, addr_b_d;
  logic [LOGN-2:0]   tw_q, tw_d;
  logic [SW-1:0]     stage_q, stage_d;

  // Descriptor arithmetic helpers
  logic [LOGN-2:0]   pos_mask;
  logic [LOGN-2:0]   pos;
  logic [LOGN-2:0]   grp;
  logic [LOGN-1:0]   half;
  logic [LOGN-1:0]   base;
  logic [SW-1:0]     tw_shift;

`ifdef NTT_SCHED_STAGE_GAP_EN
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  logic [3:0] gap_q, gap_d;
`endif

  // Next-state logic: control state, stage and butterfly counters
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef NTT_SCHED_STAGE_GAP_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          s_d     = '0;
          k_d     = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        // valid is always high in RUN, so ready alone marks a transfer
        if (ready) begin
          if (k_q == K_LAST) begin
            k_d = '0;
            if (s_q == S_LAST) begin
              state_d = ST_DONE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              s_d = s_q + SW'(1);
`ifdef NTT_SCHED_STAGE_GAP_EN
              if (GAP > 0) begin
                state_d = ST_GAP;
                valid_d = 1'b0;
                gap_d   = GAP_LOAD;
              end
`endif
            end
          end else begin
            k_d = k_q + (LOGN-1)'(1);
          end
        end
      end
`ifdef NTT_SCHED_STAGE_GAP_EN
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_RUN;
          valid_d = 1'b1;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Descriptor for the upcoming (s, k); zeroed whenever nothing is offered
  always_comb begin
    pos_mask = ~({(LOGN-1){1'b1}} << s_d);
    pos      = k_d & pos_mask;
    grp      = k_d >> s_d;
    half     = {{(LOGN-1){1'b0}}, 1'b1} << s_d;
    base     = {grp, 1'b0} << s_d;
    tw_shift = S_LAST - s_d;
    addr_a_d = '0;
    addr_b_d = '0;
    tw_d     = '0;
    stage_d  = '0;
    if (valid_d) begin
      addr_a_d = base + {1'b0, pos};
      addr_b_d = base + {1'b0, pos} + half;
      tw_d     = pos << tw_shift;
      stage_d  = s_d;
    end
  end

  // State and registered outputs; reset wins over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      k_q      <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
      stage_q  <= '0;
`ifdef NTT_SCHED_STAGE_GAP_EN
      gap_q    <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      k_q      <= k_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
      stage_q  <= stage_d;
`ifdef NTT_SCHED_STAGE_GAP_EN
      gap_q    <= gap_d;
`endif
    end
  end

  assign valid  = valid_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign addr_a = addr_a_q;
  assign addr_b = addr_b_q;
  assign tw_idx = tw_q;
  assign stage  = stage_q;

endmodule
`default_nettype wire
